// File: rtl/centroid_key_decoder.sv
// centroid_key_decoder
//   Accumulates the coordinates of flagged pixels over a frame. On tabulate it
//   divides the X/Y sums by the pixel count (restoring divider, one quotient bit
//   per cycle, both axes in parallel), maps the centroid onto a
//   KEY_COLS x KEY_ROWS zone grid, and debounces the key over STABLE_FRAMES
//   consecutive frames before committing it.
// Ports:
//   clk_in, rst_in         clock, synchronous active-high reset
//   x_in, y_in, valid_in   flagged pixel coordinates
//   tabulate_in            end-of-frame strobe (ignored while busy)
//   busy_out               frame being processed
//   centroid_x/y_out       last computed centroid
//   key_index_out          committed key (row*KEY_COLS+col)
//   key_present_out        committed key is present
//   key_valid_out          one-cycle pulse per processed frame
//   key_press_out          pulse with key_valid_out when a new present key commits
module centroid_key_decoder #(
  parameter int H_BITS        = 11,
  parameter int V_BITS        = 10,
  parameter int MAX_PIXELS    = 921600,
  parameter int KEY_COLS      = 4,
  parameter int KEY_ROWS      = 2,
  parameter int ZONE_W        = 256,
  parameter int ZONE_H        = 360,
  parameter int MIN_COUNT     = 16,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_BITS-1:0] x_in,
  input  logic [V_BITS-1:0] y_in,
  input  logic              valid_in,
  input  logic              tabulate_in,
  output logic              busy_out,
  output logic [H_BITS-1:0] centroid_x_out,
  output logic [V_BITS-1:0] centroid_y_out,
  output logic [((KEY_COLS*KEY_ROWS > 1) ? $clog2(KEY_COLS*KEY_ROWS) : 1)-1:0] key_index_out,
  output logic              key_present_out,
  output logic              key_valid_out,
  output logic              key_press_out
);
  localparam int CNT_W   = $clog2(MAX_PIXELS+1);
  localparam int ACC_X_W = H_BITS + CNT_W;
  localparam int ACC_Y_W = V_BITS + CNT_W;
  localparam int IDX_W   = (KEY_COLS*KEY_ROWS > 1) ? $clog2(KEY_COLS*KEY_ROWS) : 1;
  localparam int DCNT_W  = $clog2(ACC_X_W+1);
  localparam int SCNT_W  = $clog2(STABLE_FRAMES+1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIVIDE   = 2'd1;
  localparam logic [1:0] S_CLASSIFY = 2'd2;
  localparam logic [1:0] S_REPORT   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ACC_X_W-1:0] sum_x_q, sum_x_d, sum_x_n;
  logic [ACC_Y_W-1:0] sum_y_q, sum_y_d, sum_y_n;
  logic [CNT_W-1:0]   count_q, count_d, count_n;
  logic               pix_ok;

  logic [ACC_X_W-1:0] dvd_x_q, dvd_x_d;
  logic [ACC_Y_W-1:0] dvd_y_q, dvd_y_d;
  logic [CNT_W-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [CNT_W:0]     trial_x, trial_y;
  logic [H_BITS-1:0]  quo_x_q, quo_x_d;
  logic [V_BITS-1:0]  quo_y_q, quo_y_d;
  logic [DCNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic               raw_present_q, raw_present_d;

  logic [H_BITS-1:0]  cx_q, cx_d;
  logic [V_BITS-1:0]  cy_q, cy_d;
  logic [IDX_W-1:0]   col_c, row_c, raw_idx;
  logic               cand_present_q, cand_present_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [SCNT_W-1:0]  stable_q, stable_d;
  logic               comm_present_q, comm_present_d;
  logic [IDX_W-1:0]   comm_idx_q, comm_idx_d;
  logic               armed_q, armed_d;

  // Zone lookup: count how many zone boundaries the centroid has passed.
  // Stopping at KEY_COLS-1 / KEY_ROWS-1 boundaries gives the clamp for free.
  always_comb begin
    col_c = '0;
    row_c = '0;
    for (int k = 1; k < KEY_COLS; k++)
      if (32'(cx_q) >= 32'(k*ZONE_W)) col_c = col_c + IDX_W'(1);
    for (int k = 1; k < KEY_ROWS; k++)
      if (32'(cy_q) >= 32'(k*ZONE_H)) row_c = row_c + IDX_W'(1);
    raw_idx = raw_present_q ? (row_c * IDX_W'(KEY_COLS) + col_c) : '0;
  end

  always_comb begin
    state_d        = state_q;
    dvd_x_d        = dvd_x_q;
    dvd_y_d        = dvd_y_q;
    dvsr_d         = dvsr_q;
    rem_x_d        = rem_x_q;
    rem_y_d        = rem_y_q;
    quo_x_d        = quo_x_q;
    quo_y_d        = quo_y_q;
    div_cnt_d      = div_cnt_q;
    raw_present_d  = raw_present_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    cand_present_d = cand_present_q;
    cand_idx_d     = cand_idx_q;
    stable_d       = stable_q;
    comm_present_d = comm_present_q;
    comm_idx_d     = comm_idx_q;
    armed_d        = armed_q;
    trial_x        = {rem_x_q, dvd_x_q[ACC_X_W-1]};
    trial_y        = {rem_y_q, dvd_y_q[ACC_Y_W-1]};

    // Accumulation runs in every state so pixels arriving while busy land in
    // the next frame; saturating the count freezes the sums with it.
    pix_ok  = valid_in && (count_q < CNT_W'(MAX_PIXELS));
    sum_x_n = sum_x_q + (pix_ok ? ACC_X_W'(x_in) : '0);
    sum_y_n = sum_y_q + (pix_ok ? ACC_Y_W'(y_in) : '0);
    count_n = count_q + (pix_ok ? CNT_W'(1) : '0);
    sum_x_d = sum_x_n;
    sum_y_d = sum_y_n;
    count_d = count_n;

    case (state_q)
      S_IDLE: begin
        if (tabulate_in) begin
          dvd_x_d   = sum_x_n;
          dvd_y_d   = sum_y_n;
          dvsr_d    = count_n;
          rem_x_d   = '0;
          rem_y_d   = '0;
          quo_x_d   = '0;
          quo_y_d   = '0;
          div_cnt_d = '0;
          sum_x_d   = '0;
          sum_y_d   = '0;
          count_d   = '0;
          if (count_n < CNT_W'(MIN_COUNT)) begin
            raw_present_d = 1'b0;
            state_d       = S_CLASSIFY;
          end else begin
            raw_present_d = 1'b1;
            state_d       = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        // Quotient registers keep only the low bits: the true quotient is
        // bounded by the largest coordinate, so the shifted-out bits are zero.
        dvd_x_d = {dvd_x_q[ACC_X_W-2:0], 1'b0};
        if (trial_x >= {1'b0, dvsr_q}) begin
          rem_x_d = CNT_W'(trial_x - {1'b0, dvsr_q});
          quo_x_d = {quo_x_q[H_BITS-2:0], 1'b1};
        end else begin
          rem_x_d = trial_x[CNT_W-1:0];
          quo_x_d = {quo_x_q[H_BITS-2:0], 1'b0};
        end
        // Y dividend is one bit narrower: it finishes early and holds.
        if (div_cnt_q < DCNT_W'(ACC_Y_W)) begin
          dvd_y_d = {dvd_y_q[ACC_Y_W-2:0], 1'b0};
          if (trial_y >= {1'b0, dvsr_q}) begin
            rem_y_d = CNT_W'(trial_y - {1'b0, dvsr_q});
            quo_y_d = {quo_y_q[V_BITS-2:0], 1'b1};
          end else begin
            rem_y_d = trial_y[CNT_W-1:0];
            quo_y_d = {quo_y_q[V_BITS-2:0], 1'b0};
          end
        end
        div_cnt_d = div_cnt_q + DCNT_W'(1);
        if (div_cnt_q == DCNT_W'(ACC_X_W-1)) begin
          cx_d    = quo_x_d;
          cy_d    = quo_y_d;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        // stable_q never exceeds STABLE_FRAMES, so "not yet there" is the min().
        if (raw_present_q == cand_present_q && raw_idx == cand_idx_q) begin
          if (stable_q != SCNT_W'(STABLE_FRAMES)) stable_d = stable_q + SCNT_W'(1);
        end else begin
          cand_present_d = raw_present_q;
          cand_idx_d     = raw_idx;
          stable_d       = SCNT_W'(1);
        end
        armed_d = 1'b0;
        if (stable_d == SCNT_W'(STABLE_FRAMES) &&
            (cand_present_d != comm_present_q || cand_idx_d != comm_idx_q)) begin
          comm_present_d = cand_present_d;
          comm_idx_d     = cand_idx_d;
          armed_d        = cand_present_d;  // releases commit silently
        end
        state_d = S_REPORT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      sum_x_q        <= '0;
      sum_y_q        <= '0;
      count_q        <= '0;
      dvd_x_q        <= '0;
      dvd_y_q        <= '0;
      dvsr_q         <= '0;
      rem_x_q        <= '0;
      rem_y_q        <= '0;
      quo_x_q        <= '0;
      quo_y_q        <= '0;
      div_cnt_q      <= '0;
      raw_present_q  <= 1'b0;
      cx_q           <= '0;
      cy_q           <= '0;
      cand_present_q <= 1'b0;
      cand_idx_q     <= '0;
      stable_q       <= '0;
      comm_present_q <= 1'b0;
      comm_idx_q     <= '0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_x_q        <= sum_x_d;
      sum_y_q        <= sum_y_d;
      count_q        <= count_d;
      dvd_x_q        <= dvd_x_d;
      dvd_y_q        <= dvd_y_d;
      dvsr_q         <= dvsr_d;
      rem_x_q        <= rem_x_d;
      rem_y_q        <= rem_y_d;
      quo_x_q        <= quo_x_d;
      quo_y_q        <= quo_y_d;
      div_cnt_q      <= div_cnt_d;
      raw_present_q  <= raw_present_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      cand_present_q <= cand_present_d;
      cand_idx_q     <= cand_idx_d;
      stable_q       <= stable_d;
      comm_present_q <= comm_present_d;
      comm_idx_q     <= comm_idx_d;
      armed_q        <= armed_d;
    end
  end

  assign busy_out        = (state_q != S_IDLE);
  assign centroid_x_out  = cx_q;
  assign centroid_y_out  = cy_q;
  assign key_index_out   = comm_idx_q;
  assign key_present_out = comm_present_q;
  assign key_valid_out   = (state_q == S_REPORT);
  assign key_press_out   = (state_q == S_REPORT) && armed_q;
endmodule

// File: tb/tb_centroid_key_decoder.sv
module tb_centroid_key_decoder;
  localparam int H_BITS = 11, V_BITS = 10, MAX_PIXELS = 921600;
  localparam int KEY_COLS = 4, KEY_ROWS = 2, ZONE_W = 256, ZONE_H = 360;
  localparam int MIN_COUNT = 16, STABLE_FRAMES = 3;
  localparam int LAT_DIV   = H_BITS + $clog2(MAX_PIXELS+1) + 2;
  localparam int LAT_SHORT = 2;

  logic              clk_in = 1'b0, rst_in = 1'b1, valid_in = 1'b0, tabulate_in = 1'b0;
  logic [H_BITS-1:0] x_in = '0;
  logic [V_BITS-1:0] y_in = '0;
  logic              busy_out, key_present_out, key_valid_out, key_press_out;
  logic [H_BITS-1:0] centroid_x_out;
  logic [V_BITS-1:0] centroid_y_out;
  logic [2:0]        key_index_out;

  centroid_key_decoder dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in), .busy_out(busy_out),
    .centroid_x_out(centroid_x_out), .centroid_y_out(centroid_y_out),
    .key_index_out(key_index_out), .key_present_out(key_present_out),
    .key_valid_out(key_valid_out), .key_press_out(key_press_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected report per accepted frame.
  typedef struct {
    int t; int due; int cx; int cy; bit press; bit cp; int cidx;
  } rec_t;
  rec_t q[$];

  // Model state: current frame sums, last centroid, raw-key history, committed key.
  longint mx = 0, my = 0;
  int     mn = 0;
  int     busy_until = -1;
  int     last_cx = 0, last_cy = 0;
  int     m_comm = 0;            // present*256 + index
  int     hist[$];
  // What the DUT key outputs should currently show.
  bit     disp_p = 0;
  int     disp_idx = 0;
  int     last_valid_cyc = -1, press_cnt = 0;
  bit     last_press = 0;
  bit     started = 0;

  // Drive one cycle of inputs and advance the model for that cycle.
  task automatic drive(input bit v, input int x, input int y, input bit tab);
    valid_in = v; x_in = x[H_BITS-1:0]; y_in = y[V_BITS-1:0]; tabulate_in = tab;
    if (v && mn < MAX_PIXELS) begin mx += x; my += y; mn++; end
    if (tab && cyc > busy_until) begin
      rec_t r;
      int   raw;
      bit   same;
      r.t = cyc;
      if (mn < MIN_COUNT) begin
        r.due = cyc + LAT_SHORT;
        raw = 0;
      end else begin
        int col, row;
        last_cx = int'(mx / mn);
        last_cy = int'(my / mn);
        col = last_cx / ZONE_W; if (col > KEY_COLS-1) col = KEY_COLS-1;
        row = last_cy / ZONE_H; if (row > KEY_ROWS-1) row = KEY_ROWS-1;
        raw = 256 + row*KEY_COLS + col;
        r.due = cyc + LAT_DIV;
      end
      r.cx = last_cx; r.cy = last_cy;
      hist.push_back(raw);
      if (hist.size() > STABLE_FRAMES) void'(hist.pop_front());
      same = (hist.size() == STABLE_FRAMES);
      foreach (hist[i]) if (hist[i] != raw) same = 0;
      r.press = 0;
      if (same && raw != m_comm) begin
        m_comm = raw;
        r.press = (raw >= 256);
      end
      r.cp = (m_comm >= 256); r.cidx = m_comm % 256;
      q.push_back(r);
      busy_until = r.due;
      mx = 0; my = 0; mn = 0;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_until) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic pix(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) drive(1, x, y, 0);
  endtask

  // n pixels, the last one coinciding with tabulate.
  task automatic frame(input int n, input int x, input int y, output int tc);
    pix(n-1, x, y);
    tc = cyc;
    drive(n > 0, x, y, 1);
    wait_idle();
  endtask

  task automatic close_frame(output int tc);
    tc = cyc;
    drive(0, 0, 0, 1);
    wait_idle();
  endtask

  task automatic do_reset(input int ncyc);
    rst_in = 1; valid_in = 0; tabulate_in = 0;
    q.delete(); hist.delete();
    mx = 0; my = 0; mn = 0; busy_until = -1;
    last_cx = 0; last_cy = 0; m_comm = 0; disp_p = 0; disp_idx = 0;
    repeat (ncyc) @(posedge clk_in);
    #1;
    rst_in = 0;
    chk("rst_busy", busy_out, 0);
    chk("rst_cx", centroid_x_out, 0);
    chk("rst_cy", centroid_y_out, 0);
    chk("rst_index", key_index_out, 0);
    chk("rst_present", key_present_out, 0);
    chk("rst_valid", key_valid_out, 0);
    chk("rst_press", key_press_out, 0);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk_in) begin
    if (started && !rst_in) begin
      bit ev, eb, ep;
      ev = 0; eb = 0; ep = 0;
      if (q.size() > 0) begin
        ev = (cyc == q[0].due);
        eb = (cyc > q[0].t) && (cyc <= q[0].due);
        ep = ev && q[0].press;
      end
      chk("busy_out", busy_out, eb);
      chk("key_valid_out", key_valid_out, ev);
      chk("key_press_out", key_press_out, ep);
      if (ev) begin
        disp_p = q[0].cp; disp_idx = q[0].cidx;
        chk("centroid_x", centroid_x_out, q[0].cx);
        chk("centroid_y", centroid_y_out, q[0].cy);
        last_valid_cyc = cyc;
        last_press = key_press_out;
        if (key_press_out) press_cnt++;
        void'(q.pop_front());
      end
      chk("key_present_out", key_present_out, disp_p);
      chk("key_index_out", key_index_out, disp_idx);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int tc, tcr, pc0;
    @(posedge clk_in); #1;
    do_reset(3);
    started = 1;

    // Same cluster three times: commit on the third frame.
    frame(100, 300, 100, tc);
    chk("t1_f1_present", key_present_out, 0);
    frame(100, 300, 100, tc);
    chk("t1_f2_press", last_press, 0);
    frame(100, 300, 100, tc);
    chk("t1_latency", last_valid_cyc - tc, 33);
    chk("t1_press", last_press, 1);
    chk("t1_index", key_index_out, 1);
    chk("t1_present", key_present_out, 1);
    chk("t1_cx", centroid_x_out, 300);
    chk("t1_cy", centroid_y_out, 100);

    // Split cluster: x centroid 511 (truncated), row 1 col 1.
    for (int f = 0; f < 3; f++) begin
      pix(50, 0, 719); pix(50, 1023, 719); close_frame(tc);
    end
    chk("t2_cx", centroid_x_out, 511);
    chk("t2_cy", centroid_y_out, 719);
    chk("t2_index", key_index_out, 5);

    // Below MIN_COUNT: short path, centroid held; third such frame releases.
    pc0 = press_cnt;
    frame(10, 50, 50, tc);
    chk("t3_latency", last_valid_cyc - tc, 2);
    chk("t3_cx_held", centroid_x_out, 511);
    chk("t3_cy_held", centroid_y_out, 719);
    close_frame(tc);
    chk("t3_zero_latency", last_valid_cyc - tc, 2);
    frame(10, 50, 50, tc);
    chk("t3_release_present", key_present_out, 0);
    chk("t3_release_nopress", press_cnt, pc0);

    // Clamp at the far corner.
    for (int f = 0; f < 3; f++) frame(20, 1279, 719, tc);
    chk("t4_index", key_index_out, 7);
    chk("t4_cx", centroid_x_out, 1279);

    // Debounce A,A,B,A,A,A.
    pc0 = press_cnt;
    frame(20, 300, 100, tc); frame(20, 300, 100, tc);
    frame(20, 600, 500, tc);
    frame(20, 300, 100, tc); frame(20, 300, 100, tc);
    chk("t5_no_press_yet", press_cnt, pc0);
    chk("t5_still_7", key_index_out, 7);
    frame(20, 300, 100, tc);
    chk("t5_press", press_cnt, pc0 + 1);
    chk("t5_index", key_index_out, 1);
    for (int f = 0; f < 3; f++) close_frame(tc);
    chk("t5_release", key_present_out, 0);
    chk("t5_release_nopress", press_cnt, pc0 + 1);

    // Activity while busy: dropped tabulates, pixels carried into next frame.
    pix(20, 100, 50);
    tc = cyc; drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    pix(3, 900, 600);
    drive(1, 900, 600, 1);
    repeat (10) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    pix(1, 900, 600);
    wait_idle();
    chk("t6_latency", last_valid_cyc - tc, 33);
    chk("t6_cx", centroid_x_out, 100);
    chk("t6_cy", centroid_y_out, 50);
    pix(15, 900, 600);
    close_frame(tc);
    chk("t6_carry_cx", centroid_x_out, 900);
    chk("t6_carry_cy", centroid_y_out, 600);

    // Reset in the middle of a divide.
    pix(20, 100, 100);
    tcr = cyc; drive(0, 0, 0, 1);
    pix(5, 700, 700);
    while (cyc < tcr + 10) drive(0, 0, 0, 0);
    do_reset(1);
    repeat (40) drive(0, 0, 0, 0);
    chk("t7_no_valid", last_valid_cyc < tcr, 1);
    frame(20, 300, 100, tc);
    chk("t7_cx", centroid_x_out, 300);
    chk("t7_cy", centroid_y_out, 100);

    // Randomized frames around a drifting cluster.
    begin
      int cxr, cyr, n, nb;
      cxr = 300; cyr = 100;
      for (int f = 0; f < 40; f++) begin
        if ($urandom_range(0, 9) < 3) begin
          cxr = $urandom_range(20, 1250);
          cyr = $urandom_range(20, 690);
        end
        n = $urandom_range(0, 40);
        for (int i = 0; i < n; i++) begin
          drive(1, cxr + int'($urandom_range(0, 40)) - 20,
                   cyr + int'($urandom_range(0, 40)) - 20, 0);
          if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0);
        end
        drive(0, 0, 0, 1);
        nb = $urandom_range(0, 20);
        for (int i = 0; i < nb; i++)
          drive($urandom_range(0, 1) == 1, cxr, cyr, $urandom_range(0, 4) == 0);
        wait_idle();
      end
    end

    repeat (5) drive(0, 0, 0, 0);
    chk("end_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
